// File: rtl/watch_pkg.sv
// Shared types and constants for the watch display path: digit word layout,
// digit count and the active-low seven-segment lookup table.
package watch_pkg;

    localparam int NUM_DIGITS = 8;

    typedef struct packed {
        logic       en;
        logic [3:0] val;
        logic       dp_n;
    } digit_t;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    // Segment order {a,b,c,d,e,f,g}, active-low; codes 10..15 render as A b C d E F.
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex digit to active-low seven-segment decoder.
module seg7_decoder
    import watch_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg_n
);

    assign seg_n = SEG7_LUT[val];

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scan driver with per-slot blanking.
// Optional lamp test input is enabled by defining DISPLAY_LAMP_TEST_EN.
module display_scan_driver
    import watch_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic       clock,
    input  logic       reset,
`ifdef DISPLAY_LAMP_TEST_EN
    input  logic       lamp_test,
`endif
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    output logic [7:0] an,
    output logic [7:0] dec_ddp
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    digit_t           snap_reg, snap_next;
    logic [7:0]       an_reg, an_next;
    logic [7:0]       dec_ddp_reg, dec_ddp_next;

    digit_t           digit_words [NUM_DIGITS];
    logic [7:0]       an_sel_n;
    logic [6:0]       seg_n;
    phase_t           phase;

    assign digit_words[0] = d1;
    assign digit_words[1] = d2;
    assign digit_words[2] = d3;
    assign digit_words[3] = d4;
    assign digit_words[4] = d5;
    assign digit_words[5] = d6;
    assign digit_words[6] = d7;
    assign digit_words[7] = d8;

    // Active-low one-hot anode select for the digit currently being scanned.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign an_sel_n[gi] = ~(idx_reg == 3'(gi));
        end
    endgenerate

    seg7_decoder u_seg7 (
        .val   (snap_reg.val),
        .seg_n (seg_n)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg     <= '0;
            idx_reg     <= '0;
            snap_reg    <= '0;
            an_reg      <= 8'hFF;
            dec_ddp_reg <= 8'hFF;
        end else begin
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            snap_reg    <= snap_next;
            an_reg      <= an_next;
            dec_ddp_reg <= dec_ddp_next;
        end
    end

    // Slot timing; the 3-bit index wraps 7 -> 0 naturally.
    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        idx_next = idx_reg;
        if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            idx_next = idx_reg + 3'd1;
        end
    end

    // The digit word is latched on the last blank cycle, so the whole SHOW
    // interval displays one coherent value even if the input changes mid-slot.
    always_comb begin
        snap_next = snap_reg;
        if (cnt_reg == BLANK_LAST) begin
            snap_next = digit_words[idx_reg];
        end
    end

    assign phase = (cnt_reg < BLANK_END) ? PH_BLANK : PH_SHOW;

    always_comb begin
        an_next      = 8'hFF;
        dec_ddp_next = 8'hFF;
        if (phase == PH_SHOW) begin
            an_next      = snap_reg.en ? an_sel_n : 8'hFF;
            dec_ddp_next = {seg_n, snap_reg.dp_n};
`ifdef DISPLAY_LAMP_TEST_EN
            if (lamp_test) begin
                an_next      = an_sel_n;
                dec_ddp_next = 8'h00;
            end
`endif
        end
    end

    assign an      = an_reg;
    assign dec_ddp = dec_ddp_reg;

endmodule
